// File: rtl/mp_add_sequencer.sv
// Multi-precision adder sequencer: walks NWORDS 32-bit slices through one external
// combinational CLA32, LSW first, chaining the slice carry, then presents the full sum.
module mp_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NWORDS*32-1:0]   in_A,
  input  logic [NWORDS*32-1:0]   in_B,
  input  logic                   in_Cin,
  output logic [31:0]            operA,
  output logic [31:0]            operB,
  output logic                   Cin,
  input  logic [31:0]            resultOUT,
  input  logic                   Cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NWORDS*32-1:0]   out_sum,
  output logic                   out_Cout
);

  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [IDXW-1:0] idx_reg;
  logic            carry_reg;
  logic            out_cout_reg;

  logic [31:0]     a_word   [NWORDS];
  logic [31:0]     b_word   [NWORDS];

  logic            accept;
  logic            last_slice;

  assign accept     = (state_reg == IDLE) && in_valid;
  assign last_slice = (state_reg == ADD) && (idx_reg == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = ADD;
      ADD:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; the slice mux only selects which word is shown in ADD
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    operA     = '0;
    operB     = '0;
    Cin       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
      end
      ADD: begin
        operA = a_word[idx_reg];
        operB = b_word[idx_reg];
        Cin   = carry_reg;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Slice index and chained carry; the final carry leaves only through out_Cout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      out_cout_reg <= 1'b0;
    end else begin
      if (accept) begin
        idx_reg   <= '0;
        carry_reg <= in_Cin;
      end else if (state_reg == ADD) begin
        carry_reg <= Cout;
        if (!last_slice) begin
          idx_reg <= idx_reg + IDXW'(1);
        end
      end
      if (last_slice) begin
        out_cout_reg <= Cout;
      end
    end
  end

  assign out_Cout = out_cout_reg;

  // Per-word operand, partial-sum and output registers
  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      logic [31:0] a_reg;
      logic [31:0] b_reg;
      logic [31:0] sum_reg;
      logic [31:0] out_word_reg;
      logic [31:0] final_word;

      // The top word is still on resultOUT during the last ADD cycle
      if (gi == NWORDS - 1) begin : g_top
        assign final_word = resultOUT;
      end else begin : g_low
        assign final_word = sum_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg        <= '0;
          b_reg        <= '0;
          sum_reg      <= '0;
          out_word_reg <= '0;
        end else begin
          if (accept) begin
            a_reg <= in_A[gi*32 +: 32];
            b_reg <= in_B[gi*32 +: 32];
          end
          if ((state_reg == ADD) && (idx_reg == IDXW'(gi))) begin
            sum_reg <= resultOUT;
          end
          if (last_slice) begin
            out_word_reg <= final_word;
          end
        end
      end

      assign a_word[gi]           = a_reg;
      assign b_word[gi]           = b_reg;
      assign out_sum[gi*32 +: 32] = out_word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer: NWORDS=4 and NWORDS=1 instances, each wrapped
// around a behavioural 32-bit adder standing in for CLA32.
module tb_mp_add_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // NWORDS=4 instance
  logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [127:0] in_a, in_b, out_sum;
  logic [31:0]  opa, opb, cla_res;
  logic         cla_cin, cla_cout;

  assign {cla_cout, cla_res} = {1'b0, opa} + {1'b0, opb} + {32'd0, cla_cin};

  mp_add_sequencer #(.NWORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_a), .in_B(in_b), .in_Cin(in_cin),
    .operA(opa), .operB(opb), .Cin(cla_cin),
    .resultOUT(cla_res), .Cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_Cout(out_cout)
  );

  // NWORDS=1 instance
  logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1;
  logic [31:0] in_a1, in_b1, out_sum1, opa1, opb1, cla_res1;
  logic        cla_cin1, cla_cout1;

  assign {cla_cout1, cla_res1} = {1'b0, opa1} + {1'b0, opb1} + {32'd0, cla_cin1};

  mp_add_sequencer #(.NWORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_A(in_a1), .in_B(in_b1), .in_Cin(in_cin1),
    .operA(opa1), .operB(opb1), .Cin(cla_cin1),
    .resultOUT(cla_res1), .Cout(cla_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_Cout(out_cout1)
  );

  typedef struct packed {
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic [127:0] sum;
    logic         cout;
    logic [3:0]   cins;   // carry presented to the adder, bit i = word i
  } vec_t;

  vec_t vecs [6];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    in_a     = v.a;
    in_b     = v.b;
    in_cin   = v.cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is first seen; lat = full cycles after accept
  task automatic wait_valid(output int lat, output logic [3:0] cins);
    bit done = 0;
    lat  = 0;
    cins = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (out_valid) done = 1;
      else begin
        if (lat < 4) cins[lat] = cla_cin;
        lat++;
      end
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, " drain"}, {out_valid, in_ready}, 2'b01);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int         lat;
    logic [3:0] cins;
    start_op(v);
    wait_valid(lat, cins);
    $display("txn %s: sum=%h cout=%b latency=%0d cins=%b", name, out_sum, out_cout, lat, cins);
    check({name, " latency"}, lat, 4);
    check({name, " sum"}, out_sum, v.sum);
    check({name, " cout"}, out_cout, v.cout);
    check({name, " cin chain"}, cins, v.cins);
    drain(name);
  endtask

  initial begin
    int          lat;
    logic [3:0]  cins;
    logic [127:0] held;

    // {a, b, cin, expected sum, expected cout, expected carry per word}
    vecs[0] = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
               128'h0, 1'b1, 4'b1110};
    vecs[1] = {128'h0000_0001_0000_0000_FFFF_FFFF_0000_0000,
               128'h0000_0000_0000_0001_0000_0001_0000_0000, 1'b1,
               128'h0000_0001_0000_0002_0000_0000_0000_0001, 1'b0, 4'b0101};
    vecs[2] = {128'h1, 128'h2, 1'b0, 128'h3, 1'b0, 4'b0000};
    vecs[3] = {128'h0, 128'h0, 1'b1, 128'h1, 1'b0, 4'b0001};
    vecs[4] = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 4'b1111};
    vecs[5] = {128'h8000_0000_8000_0000_8000_0000_8000_0000,
               128'h8000_0000_8000_0000_8000_0000_8000_0000, 1'b0,
               128'h0000_0001_0000_0001_0000_0001_0000_0000, 1'b1, 4'b1110};

    rst_n = 1'b0;
    in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 0;
    in_valid1 = 0; in_a1 = '0; in_b1 = '0; in_cin1 = 0; out_ready1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle4", {in_ready, out_valid, opa, opb, cla_cin, out_cout}, {1'b1, 1'b0, 64'h0, 1'b0, 1'b0});
      check("idle1", {in_ready1, out_valid1, opa1, opb1, cla_cin1}, {1'b1, 1'b0, 64'h0, 1'b0});
    end
    check("reset sum", out_sum, 128'h0);

    // Table of directed vectors
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure in DONE with an ignored in_valid pulse
    start_op(vecs[1]);
    wait_valid(lat, cins);
    held = vecs[1].sum;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_a = 128'h5; in_b = 128'h5; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check("hold sum", out_sum, held);
      check("hold flags", {out_valid, in_ready}, 2'b10);
      @(negedge clk);
    end
    in_valid = 1'b0;
    $display("txn hold: sum=%h held 5 cycles", out_sum);
    drain("hold");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no ghost op", {out_valid, in_ready}, 2'b01);
    end

    // Reset two cycles into ADD
    start_op(vecs[0]);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset mid flags", {out_valid, in_ready, cla_cin}, 3'b010);
    @(negedge clk);
    check("reset mid sum", {out_sum, out_cout}, 129'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("after reset", {out_valid, in_ready}, 2'b01);
    end
    $display("txn reset-abort: no output presented");
    run_vec(vecs[2], "post-reset");

    // Single-word instance
    @(negedge clk);
    in_a1 = 32'hFFFF_FFFF; in_b1 = 32'hFFFF_FFFF; in_cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    check("n1 add cin", {in_ready1, out_valid1, cla_cin1}, 3'b001);
    lat = 0;
    for (int c = 0; c < 10 && !out_valid1; c++) begin
      @(posedge clk);
      #1 lat++;
    end
    $display("txn n1: sum=%h cout=%b latency=%0d", out_sum1, out_cout1, lat);
    check("n1 latency", lat, 1);
    check("n1 sum", out_sum1, 32'hFFFF_FFFF);
    check("n1 cout", out_cout1, 1'b1);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 check("n1 drain", {out_valid1, in_ready1}, 2'b01);
    out_ready1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
